// File: rtl/sdram_cmd_timer.sv
// SDRAM command-spacing timer with a free-running refresh-interval
// counter and a saturating count of owed refreshes.
module sdram_cmd_timer #(
  parameter int CNT_BITS  = 8,
  parameter int REFI_BITS = 12,
  parameter int T_RCD     = 2,
  parameter int T_CL      = 2,
  parameter int T_WR      = 2,
  parameter int T_RP      = 2,
  parameter int T_RFC     = 7,
  parameter int T_MRD     = 2,
  parameter int T_REFI    = 780,
  parameter int MAX_PEND  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  input  logic [2:0]          cmd_code,
  output logic                cmd_ready,
  output logic                cmd_err,
  output logic [CNT_BITS-1:0] busy_cnt,
  output logic                ref_req,
  output logic [3:0]          ref_pending,
  output logic                ref_overflow
);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  localparam logic [REFI_BITS-1:0] REFI_LD =
    REFI_BITS'(T_REFI - 1);
  localparam logic [3:0] PEND_MAX = 4'(MAX_PEND);

  state_t              state_q, state_d;
  logic [CNT_BITS-1:0] busy_q, busy_d;
  logic                ready_q, ready_d;
  logic                err_q, err_d;
  logic [REFI_BITS-1:0] refi_q, refi_d;
  logic [3:0]          pend_q, pend_d;
  logic                ovf_q, ovf_d;

  logic                accept;
  logic                ref_acc;
  logic                tick;
  logic [CNT_BITS-1:0] dly;

  assign accept  = cmd_valid && ready_q;
  assign ref_acc = accept && (cmd_code == 3'b101);
  assign tick    = (refi_q == '0);

  // Delay parameters wider than CNT_BITS truncate by design.
  always_comb begin
    dly = '0;
    case (cmd_code)
      3'b001:  dly = CNT_BITS'(T_RCD);
      3'b010:  dly = CNT_BITS'(T_CL);
      3'b011:  dly = CNT_BITS'(T_WR);
      3'b100:  dly = CNT_BITS'(T_RP);
      3'b101:  dly = CNT_BITS'(T_RFC);
      3'b110:  dly = CNT_BITS'(T_MRD);
      default: dly = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    ready_d = ready_q;
    err_d   = accept && (cmd_code == 3'b111);
    unique case (state_q)
      S_IDLE: begin
        if (accept && (dly != '0)) begin
          busy_d  = dly;
          ready_d = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        busy_d = busy_q - 1'b1;
        if (busy_q == CNT_BITS'(1)) begin
          ready_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        busy_d  = '0;
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    refi_d = tick ? REFI_LD : refi_q - 1'b1;
    pend_d = pend_q;
    ovf_d  = 1'b0;
    // A tick and an accepted REF cancel, even when saturated.
    if (tick && !ref_acc) begin
      if (pend_q == PEND_MAX) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + 1'b1;
      end
    end else if (ref_acc && !tick) begin
      if (pend_q != '0) begin
        pend_d = pend_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      busy_q  <= '0;
      ready_q <= 1'b1;
      err_q   <= 1'b0;
      refi_q  <= REFI_LD;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      refi_q  <= refi_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  assign cmd_ready    = ready_q;
  assign cmd_err      = err_q;
  assign busy_cnt     = busy_q;
  assign ref_pending  = pend_q;
  assign ref_req      = (pend_q != '0);
  assign ref_overflow = ovf_q;

endmodule

// File: doc/sdram_cmd_timer.md
Name: sdram_cmd_timer

Overview:
Command-spacing and refresh-interval timer that sits directly upstream of the SDRAM command path. It accepts one command code per handshake and holds cmd_ready low for that command's timing window. It uses a down-counter that it loads and decrements itself. It also runs a free-running refresh-interval down-counter and keeps a saturating count of owed refreshes, which the controller FSM consumes.

Parameters:
CNT_BITS, 8, width of the command-window down-counter and busy_cnt
REFI_BITS, 12, width of the refresh-interval counter
T_RCD, 2, cycles blocked after ACT
T_CL, 2, cycles blocked after READ
T_WR, 2, cycles blocked after WRITE
T_RP, 2, cycles blocked after PRE
T_RFC, 7, cycles blocked after REF
T_MRD, 2, cycles blocked after MRS
T_REFI, 780, cycles between refresh ticks (must be ≥2)
MAX_PEND, 8, saturation limit of owed refreshes (≤15)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
cmd_valid  input  1  command code presented
cmd_code  input  3  000 NOP, 001 ACT, 010 READ, 011 WRITE, 100 PRE, 101 REF, 110 MRS, 111 reserved
cmd_ready  output  1  timer idle; command may be accepted
cmd_err  output  1  one-cycle pulse when a reserved code is accepted
busy_cnt  output  CNT_BITS  remaining blocked cycles (0 when idle)
ref_req  output  1  high while ref_pending != 0
ref_pending  output  4  owed refresh count
ref_overflow  output  1  one-cycle pulse when a tick arrives at MAX_PEND

Behaviour:
- Reset (rst low, async): FSM = IDLE; busy_cnt = 0; cmd_ready = 1; cmd_err = 0; REFI counter = T_REFI-1; ref_pending = 0; ref_req = 0; ref_overflow = 0.
- Accept: a command is accepted when cmd_valid && cmd_ready at a rising clk edge. There is no acceptance while cmd_ready = 0, and cmd_valid is ignored then.
- FSM IDLE: on accepting a timed code with delay D > 0, load busy_cnt = D and go to WAIT. cmd_ready is registered and is 0 on the following D cycles.
- FSM IDLE with NOP, reserved code, or D = 0: stay in IDLE with cmd_ready = 1, so back-to-back acceptance is possible.
- FSM WAIT: decrement busy_cnt by 1 each cycle. When busy_cnt goes 1→0, return to IDLE, and cmd_ready = 1 in that same cycle.
- Latency: accept at edge N, then cmd_ready is low during cycles N+1..N+D and high again at edge N+D+1.
- busy_cnt never wraps. Each delay parameter must fit in CNT_BITS; this is unchecked, and values that do not fit are truncated mod 2^CNT_BITS.
- Reserved code 111: cmd_err = 1 for exactly the cycle after acceptance, and the code is otherwise treated as NOP.
- Refresh interval counter: decrements every cycle, independent of the FSM. At 0 it produces a tick and reloads T_REFI-1, so ticks are T_REFI cycles apart. The first tick comes T_REFI cycles after reset release.
- ref_pending rules, per cycle:
  - tick only: +1, saturating at MAX_PEND.
  - tick while ref_pending = MAX_PEND: hold and pulse ref_overflow for 1 cycle.
  - REF accepted only: −1, with a floor of 0. A REF accepted at 0 is legal and is still timed by T_RFC.
  - tick and REF accepted in the same cycle: unchanged. This holds even at MAX_PEND, where no overflow is raised.
- ref_req is combinational from ref_pending (ref_pending != 0).
- Reset asserted mid-WAIT: everything returns to reset values immediately, and no partial window is preserved.

Test Plan:
1. Release reset, ACT accepted at cycle 0 → cmd_ready low cycles 1–2, busy_cnt 2,1, cmd_ready high at cycle 3; a PRE presented in cycle 1 is not accepted.
2. REF accepted (T_RFC=7) → busy_cnt 7..1 over cycles 1–7, cmd_ready high at cycle 8; NOP back-to-back for 4 cycles → cmd_ready stays 1.
3. Code 111 accepted → cmd_err pulses 1 cycle, cmd_ready stays 1, busy_cnt 0.
4. T_REFI=16, no REF for 9×16 cycles → ref_pending increments to 8, ref_overflow pulses on the 9th tick, ref_req=1.
5. With ref_pending=3, accept REF in the same cycle as a tick → ref_pending stays 3. With ref_pending=0, accept REF → ref_pending stays 0 and the 7-cycle window still applies.
6. Assert rst low mid-WAIT (busy_cnt=4) asynchronously → busy_cnt=0 and cmd_ready=1 without a clock edge; after release, REFI counter restarts at T_REFI-1.
